// File: rtl/generate_gray_onehot_pkg.sv
// generate_gray_onehot_pkg
// Shared widths and helpers for the Gray / one-hot code generator.
//   A_W     : width of the unsigned binary input code
//   B_W     : width of the encoded output word
//   gray_of : binary-reflected Gray conversion of an A_W-bit value
package generate_gray_onehot_pkg;

  localparam int A_W = 3;
  localparam int B_W = 7;

  // Adjacent binary values map to Gray codes differing in a single bit.
  function automatic logic [A_W-1:0] gray_of(input logic [A_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/generate_gray_onehot_code_encoder.sv
// code_encoder
// Purely combinational encoder from a 3-bit binary code to a 7-bit word.
// Parameters:
//   USE_GRAY : 1 = Gray code in B[2:0] with B[6:3] zero,
//              0 = one-hot, A=k sets only bit k-1, A=0 gives all zeros
// Ports:
//   A (in)  : binary code, A_W bits
//   B (out) : encoded word, B_W bits
module code_encoder
  import generate_gray_onehot_pkg::*;
#(
  parameter int USE_GRAY = 1
) (
  input  logic [A_W-1:0] A,
  output logic [B_W-1:0] B
);

  // Only the selected encoding is elaborated.
  if (USE_GRAY != 0) begin : g_gray
    assign B = {{(B_W - A_W){1'b0}}, gray_of(A)};
  end else begin : g_onehot
    // A=0 is the zero code; the shift is only taken for A >= 1, so the
    // wrapped value of A-1 at A=0 never reaches B.
    always_comb begin
      B = '0;
      if (A != '0) begin
        B = B_W'(1) << (A - 3'd1);
      end
    end
  end

endmodule

// File: rtl/generate_gray_onehot.sv
// generate_gray_onehot
// Registered Gray / one-hot code generator with a one-cycle latency.
// Parameters:
//   USE_GRAY  : 1 = Gray encoding, 0 = one-hot encoding
// Ports:
//   clk       (in)  : clock, rising edge
//   rst       (in)  : asynchronous active-high reset
//   A         (in)  : 3-bit binary code, sampled when in_valid is high
//   in_valid  (in)  : sample strobe for A
//   B         (out) : registered encoded word, 7 bits
//   out_valid (out) : high for the one cycle after A was sampled
module generate_gray_onehot
  import generate_gray_onehot_pkg::*;
#(
  parameter int USE_GRAY = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [A_W-1:0] A,
  input  logic           in_valid,
  output logic [B_W-1:0] B,
  output logic           out_valid
);

  logic [B_W-1:0] encoded;

  code_encoder #(
    .USE_GRAY(USE_GRAY)
  ) u_code_encoder (
    .A(A),
    .B(encoded)
  );

  // Output stage: B loads only on a sampled input and otherwise holds;
  // out_valid mirrors the previous cycle's in_valid. Reset clears both at
  // once, which also drops any sample presented while reset was high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      B         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        B <= encoded;
      end
    end
  end

endmodule

// File: tb/tb_generate_gray_onehot.sv
// tb_generate_gray_onehot
// Directed bench driving a Gray-mode and a one-hot-mode instance from the
// same stimulus and checking both against hand-computed expected words.
module tb_generate_gray_onehot;

  logic       clk;
  logic       rst;
  logic [2:0] A;
  logic       in_valid;
  logic [6:0] b_gray;
  logic       v_gray;
  logic [6:0] b_onehot;
  logic       v_onehot;

  int assert_count;
  int fail_count;

  logic [6:0] gray_exp   [8];
  logic [6:0] onehot_exp [8];
  logic [6:0] prev_gray;

  generate_gray_onehot #(
    .USE_GRAY(1)
  ) dut_gray (
    .clk(clk),
    .rst(rst),
    .A(A),
    .in_valid(in_valid),
    .B(b_gray),
    .out_valid(v_gray)
  );

  generate_gray_onehot #(
    .USE_GRAY(0)
  ) dut_onehot (
    .clk(clk),
    .rst(rst),
    .A(A),
    .in_valid(in_valid),
    .B(b_onehot),
    .out_valid(v_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns after the
  // following rising edge.
  task automatic applyStimulus(input logic [2:0] a_val, input logic v_val);
    @(negedge clk);
    A        = a_val;
    in_valid = v_val;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [6:0] obs_b,
                             input logic obs_v, input logic [6:0] exp_b,
                             input logic exp_v);
    assert_count++;
    assert ({obs_b, obs_v} === {exp_b, exp_v})
    else begin
      fail_count++;
      $error("[TB] FAIL %s: B=%b out_valid=%b, expected B=%b out_valid=%b",
             tag, obs_b, obs_v, exp_b, exp_v);
    end
  endtask

  task automatic checkOneBit(input string tag, input logic [6:0] prev_b,
                             input logic [6:0] cur_b);
    assert_count++;
    assert ($countones(prev_b ^ cur_b) == 1)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: %b -> %b differs in %0d bits, expected 1",
             tag, prev_b, cur_b, $countones(prev_b ^ cur_b));
    end
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    gray_exp   = '{7'b0000000, 7'b0000001, 7'b0000011, 7'b0000010,
                   7'b0000110, 7'b0000111, 7'b0000101, 7'b0000100};
    onehot_exp = '{7'b0000000, 7'b0000001, 7'b0000010, 7'b0000100,
                   7'b0001000, 7'b0010000, 7'b0100000, 7'b1000000};

    // Reset state, then inputs ignored while reset is held.
    rst      = 1'b1;
    A        = 3'd0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_gray", b_gray, v_gray, 7'b0000000, 1'b0);
    checkOutput("reset_onehot", b_onehot, v_onehot, 7'b0000000, 1'b0);
    applyStimulus(3'd5, 1'b1);
    checkOutput("rst_ignores_in_gray", b_gray, v_gray, 7'b0000000, 1'b0);
    checkOutput("rst_ignores_in_onehot", b_onehot, v_onehot, 7'b0000000, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

    // Exhaustive back-to-back sweep of A=0..7 in both modes.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(3'(k), 1'b1);
      checkOutput($sformatf("gray_a%0d", k), b_gray, v_gray, gray_exp[k], 1'b1);
      checkOutput($sformatf("onehot_a%0d", k), b_onehot, v_onehot,
                  onehot_exp[k], 1'b1);
      if (k > 0) begin
        checkOneBit($sformatf("gray_adj_%0d", k), prev_gray, b_gray);
      end
      prev_gray = b_gray;
    end

    // Wrap 7 -> 0 keeps the single-bit-change property.
    applyStimulus(3'd0, 1'b1);
    checkOutput("gray_wrap", b_gray, v_gray, 7'b0000000, 1'b1);
    checkOneBit("gray_adj_wrap", prev_gray, b_gray);

    // Hold: load 5, then in_valid low with a different A.
    applyStimulus(3'd5, 1'b1);
    checkOutput("hold_load_gray", b_gray, v_gray, 7'b0000111, 1'b1);
    checkOutput("hold_load_onehot", b_onehot, v_onehot, 7'b0010000, 1'b1);
    applyStimulus(3'd2, 1'b0);
    checkOutput("hold_gray", b_gray, v_gray, 7'b0000111, 1'b0);
    checkOutput("hold_onehot", b_onehot, v_onehot, 7'b0010000, 1'b0);

    // Asynchronous reset between edges with a sample in flight.
    applyStimulus(3'd7, 1'b1);
    checkOutput("pre_rst_gray", b_gray, v_gray, 7'b0000100, 1'b1);
    @(negedge clk);
    A = 3'd6;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_gray", b_gray, v_gray, 7'b0000000, 1'b0);
    checkOutput("async_rst_onehot", b_onehot, v_onehot, 7'b0000000, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rst_held_gray", b_gray, v_gray, 7'b0000000, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("no_stale_gray", b_gray, v_gray, 7'b0000000, 1'b0);
    checkOutput("no_stale_onehot", b_onehot, v_onehot, 7'b0000000, 1'b0);

    // Recovery with normal latency.
    applyStimulus(3'd3, 1'b1);
    checkOutput("recover_gray", b_gray, v_gray, 7'b0000010, 1'b1);
    checkOutput("recover_onehot", b_onehot, v_onehot, 7'b0000100, 1'b1);
    applyStimulus(3'd3, 1'b0);
    checkOutput("recover_drop_gray", b_gray, v_gray, 7'b0000010, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
